// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and the clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int OVERSAMPLE = 16;
   localparam int OS_W       = clog2(OVERSAMPLE);

   // Divisors for a 100 MHz main_clk at 16x oversampling
   localparam int DIV_9600   = 651;
   localparam int DIV_115200 = 54;
   localparam int DIV_921600 = 7;

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Counter 0..i_last with enable, synchronous clear and wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_last,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap
);

   logic [WIDTH-1:0] r_count;
   logic             w_wrap;

   // >= keeps the counter bounded if i_last shrinks below the held count
   assign w_wrap  = i_en & ~i_clr & (r_count >= i_last);
   assign o_wrap  = w_wrap;
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_wrap ? '0 : r_count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Oversample / mid-bit / baud clock-enable tick generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
   parameter int CNT_W       = 16,
   parameter int OVERSAMPLE  = 16,
   parameter int DEFAULT_DIV = uart_pkg::DIV_115200
) (
   input  logic             main_clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] divisor,
   input  logic             load,
   input  logic             resync,
   output logic             os_tick,
   output logic             mid_tick,
   output logic             baud_tick,
   output logic             baud_clk,
   output logic [CNT_W-1:0] active_div
);
   import uart_pkg::*;

   localparam int                c_os_w        = clog2(OVERSAMPLE);
   localparam logic [c_os_w-1:0] c_os_last     = c_os_w'(OVERSAMPLE - 1);
   localparam logic [c_os_w-1:0] c_os_mid_prev = c_os_w'(OVERSAMPLE / 2 - 1);

   if ((OVERSAMPLE < 2) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
      $error("OVERSAMPLE must be even and >= 2");
   end

   logic [CNT_W-1:0]  r_active_div;
   logic [CNT_W-1:0]  r_pend_div;
   logic              r_pend_valid;
   logic              r_os_tick;
   logic              r_mid_tick;
   logic              r_baud_tick;
   logic              r_baud_clk;

   logic [CNT_W-1:0]  w_div_last;
   logic [CNT_W-1:0]  w_div_cnt_unused;
   logic [c_os_w-1:0] w_os_cnt;
   logic              w_boundary;
   logic              w_os_wrap;
   logic              w_mid;
   logic              w_apply;
   logic              w_pend_any;
   logic [CNT_W-1:0]  w_next_div;

   // A divisor of 0 runs as 1
   assign w_div_last = (r_active_div == '0) ? '0 : r_active_div - CNT_W'(1);

   mod_counter #(.WIDTH(CNT_W)) u_div_cnt (
      .clk     (main_clk),
      .rst_n   (reset_n),
      .i_en    (enable),
      .i_clr   (resync),
      .i_last  (w_div_last),
      .o_count (w_div_cnt_unused),
      .o_wrap  (w_boundary)
   );

   mod_counter #(.WIDTH(c_os_w)) u_os_cnt (
      .clk     (main_clk),
      .rst_n   (reset_n),
      .i_en    (w_boundary),
      .i_clr   (resync),
      .i_last  (c_os_last),
      .o_count (w_os_cnt),
      .o_wrap  (w_os_wrap)
   );

   assign w_mid      = w_boundary & (w_os_cnt == c_os_mid_prev);
   // New divisors only take effect where no period is in flight
   assign w_apply    = resync | ~enable | w_boundary;
   assign w_pend_any = load | r_pend_valid;
   assign w_next_div = load ? divisor : r_pend_div;

   always_ff @(posedge main_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active_div <= CNT_W'(DEFAULT_DIV);
         r_pend_div   <= '0;
         r_pend_valid <= 1'b0;
         r_os_tick    <= 1'b0;
         r_mid_tick   <= 1'b0;
         r_baud_tick  <= 1'b0;
         r_baud_clk   <= 1'b0;
      end else begin
         r_os_tick   <= w_boundary;
         r_mid_tick  <= w_mid;
         r_baud_tick <= w_os_wrap;

         if (resync) begin
            r_baud_clk <= 1'b0;
         end else if (w_mid || w_os_wrap) begin
            r_baud_clk <= ~r_baud_clk;
         end

         if (load) r_pend_div <= divisor;

         if (w_apply) begin
            if (w_pend_any) r_active_div <= w_next_div;
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign os_tick    = r_os_tick;
   assign mid_tick   = r_mid_tick;
   assign baud_tick  = r_baud_tick;
   assign baud_clk   = r_baud_clk;
   assign active_div = r_active_div;

endmodule
`default_nettype wire
